// File: rtl/lcd_dma_axi_reader.sv
// -----------------------------------------------------------------------------
// lcd_dma_axi_reader
//
// Purpose:
//   Burst-read engine that feeds the LCD frame-buffer FIFO. It takes one
//   burst request from lcd_dma_fifo, issues a single AXI3 INCR read burst on a
//   64-bit HP master port and hands every 64-bit beat back as two consecutive
//   32-bit words (low half first). Single clock domain (CLK), synchronous
//   active-high RESET.
//
// Parameters:
//   BURST_BEATS : 64-bit beats per burst (1..16), ARLEN = BURST_BEATS-1
//   AXI_ID      : constant ARID value (6 bits)
//
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   DMA_RD_ADDR[29:0]       burst start address in 8-byte units
//   DMA_START               request pulse, honoured only while DMA_READY=1
//   DMA_READY               idle and able to accept a start
//   DMA_RD_DATA[31:0]       returned word, 0 whenever DMA_RD_DATA_VALID=0
//   DMA_RD_DATA_VALID       one cycle per returned word
//   M_AXI_AR*               AXI3 read address channel (constant attributes)
//   M_AXI_R*                AXI3 read data channel
//   DBG_STATE[1:0]          current FSM state (0=IDLE, 1=ADDR, 2=DATA)
//   DMA_ERROR               sticky error flag (only with LCD_DMA_ERR_CHECK_EN)
//
// Configuration:
//   LCD_DMA_ERR_CHECK_EN    when defined, adds DMA_ERROR plus a beat counter;
//                           the flag is set on a non-OKAY RRESP or on an RLAST
//                           that arrives on a beat count other than BURST_BEATS.
//
// Handshake rules: a transfer happens on a rising CLK edge where both VALID
// and READY are 1. ARVALID stays high with stable ARADDR until ARREADY; RREADY
// is only offered while the holding register can absorb a full beat. On the
// DMA side DMA_START is a request that only counts while DMA_READY=1; returned
// words are pushed (no backpressure) with DMA_RD_DATA_VALID.
// -----------------------------------------------------------------------------
module lcd_dma_axi_reader #(
   parameter int unsigned BURST_BEATS = 4,
   parameter int unsigned AXI_ID      = 0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [29:0] DMA_RD_ADDR,
   input  logic        DMA_START,
   output logic        DMA_READY,
   output logic [31:0] DMA_RD_DATA,
   output logic        DMA_RD_DATA_VALID,
   output logic [31:0] M_AXI_ARADDR,
   output logic [3:0]  M_AXI_ARLEN,
   output logic [2:0]  M_AXI_ARSIZE,
   output logic [1:0]  M_AXI_ARBURST,
   output logic [3:0]  M_AXI_ARCACHE,
   output logic [2:0]  M_AXI_ARPROT,
   output logic [5:0]  M_AXI_ARID,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [63:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RLAST,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY,
   output logic [1:0]  DBG_STATE
`ifdef LCD_DMA_ERR_CHECK_EN
   ,
   output logic        DMA_ERROR
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Address bit 29 does not fit a 32-bit byte address and is dropped.
   logic [28:0] addr_q;
   logic [63:0] hold_q;
   logic [1:0]  pending;     // halves of hold_q still to be emitted
   logic        last_seen;   // RLAST already accepted for this burst

   logic        start_acc;
   logic        beat_acc;

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next state and handshake outputs
   // --------------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      DMA_READY     = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      case (state)
         ST_IDLE: begin
            DMA_READY = 1'b1;
            if (DMA_START) begin
               state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            M_AXI_ARVALID = 1'b1;
            if (M_AXI_ARREADY) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            // Accept a new beat only when at most one half is still queued:
            // that half drains in the same cycle the new beat is loaded.
            M_AXI_RREADY = (pending != 2'd2) && !last_seen;
            // Leave while the final high half is on the output so that
            // DMA_READY rises in the cycle right after it.
            if (last_seen && (pending != 2'd2)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign DBG_STATE = state;
   assign start_acc = DMA_READY && DMA_START;
   assign beat_acc  = M_AXI_RREADY && M_AXI_RVALID;

   // --------------------------------------------------------------------------
   // Address latch, holding register and pending-half counter
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         addr_q    <= '0;
         hold_q    <= '0;
         pending   <= 2'd0;
         last_seen <= 1'b0;
      end else begin
         if (start_acc) begin
            addr_q    <= DMA_RD_ADDR[28:0];
            last_seen <= 1'b0;
         end
         if (beat_acc) begin
            hold_q    <= M_AXI_RDATA;
            pending   <= 2'd2;
            last_seen <= M_AXI_RLAST;
         end else if (pending != 2'd0) begin
            pending <= pending - 2'd1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Word output: pending=2 shows the low half, pending=1 the high half.
   // --------------------------------------------------------------------------
   always_comb begin
      DMA_RD_DATA       = 32'd0;
      DMA_RD_DATA_VALID = 1'b0;
      case (pending)
         2'd2: begin
            DMA_RD_DATA       = hold_q[31:0];
            DMA_RD_DATA_VALID = 1'b1;
         end
         2'd1: begin
            DMA_RD_DATA       = hold_q[63:32];
            DMA_RD_DATA_VALID = 1'b1;
         end
         default: begin
            DMA_RD_DATA       = 32'd0;
            DMA_RD_DATA_VALID = 1'b0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Read address channel: address from the latch, constant attributes
   // --------------------------------------------------------------------------
   assign M_AXI_ARADDR  = {addr_q, 3'b000};
   assign M_AXI_ARLEN   = 4'(BURST_BEATS - 1);
   assign M_AXI_ARSIZE  = 3'b011;    // 8 bytes per beat
   assign M_AXI_ARBURST = 2'b01;     // INCR
   assign M_AXI_ARCACHE = 4'b0011;   // bufferable, modifiable
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARID    = 6'(AXI_ID);

`ifdef LCD_DMA_ERR_CHECK_EN
   // --------------------------------------------------------------------------
   // Sticky error: bad response or a burst length other than BURST_BEATS.
   // Data is still delivered unchanged.
   // --------------------------------------------------------------------------
   logic [4:0] beat_cnt;   // beats accepted so far in this burst
   logic       err_q;
   logic       unused_bits;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         beat_cnt <= 5'd0;
         err_q    <= 1'b0;
      end else begin
         if (start_acc) begin
            beat_cnt <= 5'd0;
         end else if (beat_acc) begin
            beat_cnt <= beat_cnt + 5'd1;
         end
         if (beat_acc &&
             ((M_AXI_RRESP != 2'b00) ||
              (M_AXI_RLAST && ((beat_cnt + 5'd1) != 5'(BURST_BEATS))))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign DMA_ERROR   = err_q;
   assign unused_bits = DMA_RD_ADDR[29];
`else
   // RRESP has no consumer without the error check; address bit 29 never has.
   logic unused_bits;
   assign unused_bits = ^{DMA_RD_ADDR[29], M_AXI_RRESP};
`endif

endmodule

// File: tb/tb_lcd_dma_axi_reader.sv
// -----------------------------------------------------------------------------
// tb_lcd_dma_axi_reader
//
// Directed bench for lcd_dma_axi_reader (BURST_BEATS=4, AXI_ID=0). A small
// AXI slave answers each read burst with beats {hi=seed+2i+1, lo=seed+2i};
// the expected word stream is queued per burst from that rule and a single
// negedge process compares every DUT output cycle against it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_dma_axi_reader;

   localparam int BEATS = 4;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- DUT wiring
   logic [29:0] dma_rd_addr;
   logic        dma_start;
   logic        dma_ready;
   logic [31:0] dma_rd_data;
   logic        dma_rd_data_valid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic [5:0]  arid;
   logic        arvalid;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [1:0]  dbg_state;
`ifdef LCD_DMA_ERR_CHECK_EN
   logic        dma_error;
`endif

   lcd_dma_axi_reader #(
      .BURST_BEATS (BEATS),
      .AXI_ID      (0)
   ) dut (
      .CLK               (clk),
      .RESET             (rst),
      .DMA_RD_ADDR       (dma_rd_addr),
      .DMA_START         (dma_start),
      .DMA_READY         (dma_ready),
      .DMA_RD_DATA       (dma_rd_data),
      .DMA_RD_DATA_VALID (dma_rd_data_valid),
      .M_AXI_ARADDR      (araddr),
      .M_AXI_ARLEN       (arlen),
      .M_AXI_ARSIZE      (arsize),
      .M_AXI_ARBURST     (arburst),
      .M_AXI_ARCACHE     (arcache),
      .M_AXI_ARPROT      (arprot),
      .M_AXI_ARID        (arid),
      .M_AXI_ARVALID     (arvalid),
      .M_AXI_ARREADY     (arready),
      .M_AXI_RDATA       (rdata),
      .M_AXI_RRESP       (rresp),
      .M_AXI_RLAST       (rlast),
      .M_AXI_RVALID      (rvalid),
      .M_AXI_RREADY      (rready),
      .DBG_STATE         (dbg_state)
`ifdef LCD_DMA_ERR_CHECK_EN
      ,
      .DMA_ERROR         (dma_error)
`endif
   );

   // ---------------------------------------------------------------- scoreboard
   logic [31:0] exp_q[$];
   logic [31:0] exp_araddr = 32'd0;
   int          word_cyc[$];
   int          n_words  = 0;
   int          ar_count = 0;
   logic        prev_arvalid = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One compare process: every cycle out of reset.
   always @(negedge clk) begin
      if (rst) begin
         prev_arvalid = 1'b0;
      end else begin
         if (dma_rd_data_valid) begin
            word_cyc.push_back(cyc);
            n_words++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_word actual=%0h required=none (cycle %0d)", dma_rd_data, cyc);
            end else begin
               logic [31:0] w;
               w = exp_q.pop_front();
               n_checks--;
               check("rd_data", 64'(dma_rd_data), 64'(w));
            end
         end else begin
            check("rd_data_zero_when_invalid", 64'(dma_rd_data), 64'd0);
         end
         if (arvalid) begin
            check("araddr", 64'(araddr), 64'(exp_araddr));
            check("ar_attrs", 64'({arlen, arsize, arburst, arcache, arprot, arid}),
                  64'({4'(BEATS - 1), 3'd3, 2'd1, 4'd3, 3'd0, 6'd0}));
            if (!prev_arvalid) ar_count++;
         end
         prev_arvalid = arvalid;
      end
   end

   // ---------------------------------------------------------------- AXI slave
   logic [31:0] s_seed     = 32'd0;
   int          s_last_idx = BEATS - 1;
   int          s_ar_delay = 0;
   int          s_r_gap    = 0;
   int          s_bad_beat = -1;

   task automatic slave_burst();
      bit aborted = 1'b0;
      bit taken;
      for (int d = 0; d < s_ar_delay && !aborted; d++) begin
         @(negedge clk);
         if (rst) aborted = 1'b1;
      end
      if (!aborted) begin
         arready = 1'b1;
         @(negedge clk);
         arready = 1'b0;
         if (rst) aborted = 1'b1;
      end
      for (int i = 0; i <= s_last_idx && !aborted; i++) begin
         for (int g = 0; g < s_r_gap && !aborted; g++) begin
            rvalid = 1'b0;
            @(negedge clk);
            if (rst) aborted = 1'b1;
         end
         if (!aborted) begin
            rvalid = 1'b1;
            rdata  = {s_seed + 32'(2 * i + 1), s_seed + 32'(2 * i)};
            rresp  = (i == s_bad_beat) ? 2'b10 : 2'b00;
            rlast  = (i == s_last_idx);
            taken  = 1'b0;
            while (!taken && !aborted) begin
               if (rready) taken = 1'b1;
               @(negedge clk);
               if (rst) aborted = 1'b1;
            end
`ifdef LCD_DMA_ERR_CHECK_EN
            if (taken && !aborted && i == s_bad_beat)
               check("error_cycle_after_bad_beat", 64'(dma_error), 64'd1);
`endif
         end
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      rdata  = 64'd0;
   endtask

   initial begin : axi_slave
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = 64'd0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && arvalid) slave_burst();
      end
   end

   // ---------------------------------------------------------------- drivers
   // Queues the expected words, then pulses DMA_START for one cycle.
   // Returns at the negedge of the cycle after the start was sampled.
   task automatic run_burst(input logic [29:0] addr, input logic [31:0] seed,
                            input int last_idx, input int ar_delay, input int r_gap,
                            input int bad_beat, output int start_cyc);
      int b = 0;
      @(negedge clk);
      while (!dma_ready && b < 100) begin
         @(negedge clk);
         b++;
      end
      check("ready_before_start", 64'(dma_ready), 64'd1);
      s_seed     = seed;
      s_last_idx = last_idx;
      s_ar_delay = ar_delay;
      s_r_gap    = r_gap;
      s_bad_beat = bad_beat;
      for (int i = 0; i <= last_idx; i++) begin
         exp_q.push_back(seed + 32'(2 * i));
         exp_q.push_back(seed + 32'(2 * i + 1));
      end
      // Byte address of an 8-byte unit address, modulo the 32-bit space.
      exp_araddr  = 32'((64'(addr) % 64'(1 << 29)) * 8);
      dma_rd_addr = addr;
      dma_start   = 1'b1;
      start_cyc   = cyc;
      @(negedge clk);
      dma_start   = 1'b0;
      dma_rd_addr = ~addr;
   endtask

   // Waits until all queued words are out and DMA_READY is back.
   task automatic wait_done(input string name, output int ready_cyc);
      int b = 0;
      while (!(exp_q.size() == 0 && dma_ready) && b < 300) begin
         @(negedge clk);
         b++;
      end
      ready_cyc = cyc;
      check({name, "_done_in_time"}, 64'(exp_q.size() == 0 && dma_ready), 64'd1);
   endtask

   // ---------------------------------------------------------------- tests
   initial begin : main
      int sc;
      int rc;
      int w0;
      int a0;
      int b;
      dma_rd_addr = 30'd0;
      dma_start   = 1'b0;

      // Reset: 5 cycles
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_ready", 64'(dma_ready), 64'd1);
      check("reset_arvalid", 64'(arvalid), 64'd0);
      check("reset_rready", 64'(rready), 64'd0);
      check("reset_valid", 64'(dma_rd_data_valid), 64'd0);
      check("reset_data", 64'(dma_rd_data), 64'd0);
`ifdef LCD_DMA_ERR_CHECK_EN
      check("reset_error", 64'(dma_error), 64'd0);
`endif
      rst = 1'b0;

      // Single burst, zero-wait slave
      word_cyc.delete();
      w0 = n_words;
      a0 = ar_count;
      run_burst(30'h1000_0000, 32'h0, BEATS - 1, 0, 0, -1, sc);
      check("single_arvalid_cycle1", 64'(arvalid), 64'd1);
      check("single_ready_low", 64'(dma_ready), 64'd0);
      check("single_araddr_literal", 64'(araddr), 64'h8000_0000);
      check("single_arlen_literal", 64'(arlen), 64'd3);
      wait_done("single", rc);
      check("single_words", 64'(n_words - w0), 64'd8);
      check("single_ar_count", 64'(ar_count - a0), 64'd1);
      if (word_cyc.size() == 8) begin
         check("single_first_word_cycle", 64'(word_cyc[0] - sc), 64'd3);
         check("single_last_word_cycle", 64'(word_cyc[7] - sc), 64'd10);
      end
      check("single_ready_return_cycle", 64'(rc - sc), 64'd11);

      // Backpressure: ARREADY after 5 cycles, 3-cycle RVALID gaps, bit 29 set
      w0 = n_words;
      a0 = ar_count;
      run_burst(30'h3000_0001, 32'hA000_0000, BEATS - 1, 5, 3, -1, sc);
      check("bp_araddr_literal", 64'(araddr), 64'h8000_0008);
      wait_done("bp", rc);
      check("bp_words", 64'(n_words - w0), 64'd8);
      check("bp_ar_count", 64'(ar_count - a0), 64'd1);

      // Ignored start during DATA
      w0 = n_words;
      a0 = ar_count;
      run_burst(30'h0000_0100, 32'h5555_0000, BEATS - 1, 0, 1, -1, sc);
      b = 0;
      while (n_words - w0 < 1 && b < 50) begin
         @(negedge clk);
         b++;
      end
      dma_rd_addr = 30'h0000_0200;
      dma_start   = 1'b1;
      @(negedge clk);
      dma_start   = 1'b0;
      wait_done("ignored", rc);
      repeat (6) @(negedge clk);
      check("ignored_words", 64'(n_words - w0), 64'd8);
      check("ignored_ar_count", 64'(ar_count - a0), 64'd1);

      // Short burst: RLAST on beat 1 delivers 4 words
      w0 = n_words;
      run_burst(30'h0000_0040, 32'h0BAD_0000, 1, 0, 0, -1, sc);
      wait_done("short", rc);
      repeat (4) @(negedge clk);
      check("short_words", 64'(n_words - w0), 64'd4);
`ifdef LCD_DMA_ERR_CHECK_EN
      check("short_error", 64'(dma_error), 64'd1);
`endif

      // Reset after 3 words, then a fresh burst
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      w0 = n_words;
      run_burst(30'h0000_0040, 32'h1234_0000, BEATS - 1, 0, 0, -1, sc);
      b = 0;
      while (n_words - w0 < 3 && b < 50) begin
         @(negedge clk);
         #1;
         b++;
      end
      check("midrst_three_words", 64'(n_words - w0), 64'd3);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_valid", 64'(dma_rd_data_valid), 64'd0);
      check("midrst_ready", 64'(dma_ready), 64'd1);
      check("midrst_arvalid", 64'(arvalid), 64'd0);
`ifdef LCD_DMA_ERR_CHECK_EN
      check("midrst_error_cleared", 64'(dma_error), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      w0 = n_words;
      run_burst(30'h0000_0080, 32'h7777_0000, BEATS - 1, 2, 1, -1, sc);
      check("fresh_araddr_literal", 64'(araddr), 64'h0000_0400);
      wait_done("fresh", rc);
      check("fresh_words", 64'(n_words - w0), 64'd8);

`ifdef LCD_DMA_ERR_CHECK_EN
      // Error: RRESP=SLVERR on beat 2, all words still delivered
      check("pre_err_clear", 64'(dma_error), 64'd0);
      w0 = n_words;
      run_burst(30'h0000_0010, 32'hE000_0000, BEATS - 1, 0, 0, 2, sc);
      wait_done("rresp", rc);
      check("rresp_words", 64'(n_words - w0), 64'd8);
      check("rresp_error_sticky", 64'(dma_error), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
